alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 124 ++++++++++++
 tb/tb_alu_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Registered ALU with single-cycle logic/arithmetic ops and an 8-iteration
// shift-add multiplier; one done pulse per completed operation.
module alu_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   opcode,
  input  logic [W-1:0] acin,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] alout,
  output logic         done,
  output logic         busy,
  output logic         cf,
  output logic         zf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int CW = $clog2(W) + 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     alout_reg;
  logic             cf_reg, zf_reg, done_reg;
  logic [2*W-1:0]   mcand_reg, prod_reg, prod_next;
  logic [W-1:0]     mplier_reg;
  logic [CW-1:0]    count_reg;
  logic             last_iter, accept;

  logic [W:0]       sum, diff;
  logic [W-1:0]     alu_res;
  logic             alu_cf;

  assign accept    = start && (state_reg == IDLE);
  assign last_iter = (count_reg == CW'(W - 1));
  // Final iteration folds its partial product in combinationally so the
  // result can be loaded on the same edge that returns the FSM to IDLE.
  assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

  assign sum  = {1'b0, acin} + {1'b0, opnd};
  assign diff = {1'b0, acin} - {1'b0, opnd};

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    case (opcode)
      OP_ADD: begin alu_res = sum[W-1:0];  alu_cf = sum[W];  end
      OP_SUB: begin alu_res = diff[W-1:0]; alu_cf = diff[W]; end
      OP_AND: alu_res = acin & opnd;
      OP_OR:  alu_res = acin | opnd;
      OP_XOR: alu_res = acin ^ opnd;
      OP_NOT: alu_res = ~acin;
      OP_SHL: begin alu_res = {acin[W-2:0], 1'b0}; alu_cf = acin[W-1]; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && opcode == OP_MUL) state_next = MUL;
      MUL:  if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      alout_reg  <= '0;
      cf_reg     <= 1'b0;
      zf_reg     <= 1'b0;
      done_reg   <= 1'b0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      if (accept) begin
        if (opcode == OP_MUL) begin
          mcand_reg  <= {{W{1'b0}}, acin};
          mplier_reg <= opnd;
          prod_reg   <= '0;
          count_reg  <= '0;
        end else begin
          alout_reg <= alu_res;
          cf_reg    <= alu_cf;
          zf_reg    <= (alu_res == '0);
          done_reg  <= 1'b1;
        end
      end else if (state_reg == MUL) begin
        prod_reg   <= prod_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
        if (last_iter) begin
          alout_reg <= prod_next[W-1:0];
          cf_reg    <= |prod_next[2*W-1:W];
          zf_reg    <= (prod_next[W-1:0] == '0);
          done_reg  <= 1'b1;
        end
      end
    end
  end

  assign alout = alout_reg;
  assign cf    = cf_reg;
  assign zf    = zf_reg;
  assign done  = done_reg;
  assign busy  = (state_reg == MUL);

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_alu_unit;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, NOT_ = 3'b101, SHL = 3'b110, MUL = 3'b111;

  logic       clk, rst, start;
  logic [2:0] opcode;
  logic [7:0] acin, opnd, alout;
  logic       done, busy, cf, zf;

  typedef struct {
    logic [7:0] al;
    logic       c;
    logic       z;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  alu_unit #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .acin(acin),
    .opnd(opnd), .alout(alout), .done(done), .busy(busy), .cf(cf), .zf(zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 alout=%0h expected no result", alout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, "_alout"}, 16'(alout), 16'(e.al));
        check({e.nm, "_cf"}, 16'(cf), 16'(e.c));
        check({e.nm, "_zf"}, 16'(zf), 16'(e.z));
        $display("result %s: alout=%02h cf=%0d zf=%0d", e.nm, alout, cf, zf);
      end
    end
  end

  task automatic expect_res(input logic [7:0] al, input logic c, input logic z, input string nm);
    exp_t e;
    e.al = al; e.c = c; e.z = z; e.nm = nm;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; opcode = op; acin = a; opnd = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic op1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] al, input logic c, input logic z, input string nm);
    expect_res(al, c, z, nm);
    issue(op, a, b);
    @(negedge clk);
    check({nm, "_done"}, 16'(done), 16'd1);
    @(posedge clk); #1;
  endtask

  task automatic mul_timed(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] al, input logic c, input logic z, input string nm);
    expect_res(al, c, z, nm);
    issue(MUL, a, b);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check({nm, "_busy"}, 16'(busy), 16'd1);
      check({nm, "_done_early"}, 16'(done), 16'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({nm, "_done"}, 16'(done), 16'd1);
    check({nm, "_busy_clear"}, 16'(busy), 16'd0);
    @(posedge clk); #1;
  endtask

  // Bounded wait for done; returns at the negedge where done is seen.
  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({nm, "_done_seen"}, 16'(seen), 16'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b1; opcode = ADD; acin = 8'hF0; opnd = 8'h20;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_alout", 16'(alout), 16'h00);
    check("rst_cf", 16'(cf), 16'd0);
    check("rst_zf", 16'(zf), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    @(posedge clk); #1;

    op1(ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, "add_f0_20");
    @(negedge clk);
    check("add_done_one_cycle", 16'(done), 16'd0);
    @(posedge clk); #1;
    op1(SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, "sub_05_05");
    op1(SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_03_05");
    op1(ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, "add_ff_01");
    op1(AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, "and_f0_3c");
    op1(OR_, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, "or_0f_30");

    mul_timed(8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0, "mul_0c_0b");
    mul_timed(8'h20, 8'h10, 8'h00, 1'b1, 1'b1, "mul_20_10");

    // ADD request at the third multiply iteration must be ignored.
    expect_res(8'h3F, 1'b0, 1'b0, "mul_07_09_ign");
    d0 = done_cnt;
    issue(MUL, 8'h07, 8'h09);
    @(posedge clk); #1;
    start = 1'b1; opcode = ADD; acin = 8'h01; opnd = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("mul_ign");
    repeat (4) @(posedge clk);
    #1;
    check("mul_ign_single_done", 16'(done_cnt - d0), 16'd1);

    // Reset at the fourth iteration aborts the multiply.
    issue(MUL, 8'h0C, 8'h0B);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_alout", 16'(alout), 16'h00);
    check("abort_done", 16'(done), 16'd0);
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 16'(done_cnt - d0), 16'd0);

    expect_res(8'h55, 1'b0, 1'b0, "xor_aa_ff");
    expect_res(8'hFF, 1'b0, 1'b0, "not_00");
    start = 1'b1; opcode = XOR_; acin = 8'hAA; opnd = 8'hFF;
    @(posedge clk); #1;
    opcode = NOT_; acin = 8'h00;
    @(negedge clk);
    check("b2b_done_1", 16'(done), 16'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_done_2", 16'(done), 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_done_low", 16'(done), 16'd0);
    @(posedge clk); #1;

    op1(SHL, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, "shl_81");

    // New start accepted in the cycle done pulses after a multiply.
    expect_res(8'h0F, 1'b0, 1'b0, "mul_03_05");
    issue(MUL, 8'h03, 8'h05);
    wait_done("mul_03_05");
    expect_res(8'h03, 1'b0, 1'b0, "add_after_mul");
    start = 1'b1; opcode = ADD; acin = 8'h01; opnd = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("add_after_mul_done", 16'(done), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
